// File: rtl/pwm_pkg.sv
// Shared constants for the PWM breathing sequencer: default sizing, FSM encodings
// and the power-on duty table.
package pwm_pkg;

    localparam int unsigned PERIOD_DEF  = 500000;
    localparam int unsigned REPEAT_DEF  = 200;
    localparam int unsigned STEPS_DEF   = 10;
    localparam int unsigned CW_DEF      = 19;
    localparam int unsigned TABLE_DEPTH = 16;
    localparam int unsigned IW          = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Power-on breathing curve; entries past the tenth come up as 0.
    function automatic int unsigned default_entry(input int unsigned idx);
        case (idx)
            0:       return 475000;
            1:       return 425000;
            2:       return 350000;
            3:       return 250000;
            4:       return 100000;
            5:       return 100000;
            6:       return 250000;
            7:       return 350000;
            8:       return 425000;
            9:       return 475000;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// PWM period datapath: period counter, end-of-period strobe, per-period duty latch
// and the registered compare that drives the LED.
module pwm_period_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] duty_in,
    output logic          led,
    output logic          period_end
);

    logic [CW-1:0] pcnt;
    logic [CW-1:0] pcnt_next;
    logic [CW-1:0] duty_q;
    logic [CW-1:0] duty_c;

    // At pcnt=0 the fresh table value is used directly so the first cycle of a
    // period already compares against the new duty.
    always_comb begin
        pcnt_next = pcnt + CW'(1);
        duty_c    = duty_q;
        if (pcnt == CW'(PERIOD - 1)) begin
            pcnt_next = '0;
        end
        if (pcnt == '0) begin
            duty_c = duty_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            duty_q     <= '0;
            led        <= 1'b1;
            period_end <= 1'b0;
        end else if (!en) begin
            pcnt       <= '0;
            led        <= 1'b1;
            period_end <= 1'b0;
        end else begin
            pcnt       <= pcnt_next;
            duty_q     <= duty_c;
            led        <= (pcnt < duty_c);
            period_end <= (pcnt_next == CW'(PERIOD - 1));
        end
    end

endmodule

// File: rtl/pwm_breath_sequencer.sv
// Breathing-pattern sequencer: owns the duty table, repeat/step counters and the
// IDLE/RUN control FSM; the PWM period itself comes from pwm_period_gen.
module pwm_breath_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned REPEAT = REPEAT_DEF,
    parameter int unsigned STEPS  = STEPS_DEF,
    parameter int unsigned CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          led,
    output logic          busy,
    output logic [IW-1:0] step_idx,
    output logic          done
);

    localparam int unsigned RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_next;
    logic [IW-1:0] step_next;
    logic          done_next;
    logic          en_c;
    logic          period_end;
    logic [CW-1:0] duty_c;
    logic [CW-1:0] table_q [TABLE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rcnt     <= '0;
            step_idx <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            rcnt     <= rcnt_next;
            step_idx <= step_next;
            done     <= done_next;
            busy     <= (state_next == RUN);
        end
    end

    // Stop beats start in IDLE; the end-of-sequence decision samples loop_en here.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        step_next  = step_idx;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                    step_next  = '0;
                end else if (period_end) begin
                    if (rcnt == RW'(REPEAT - 1)) begin
                        rcnt_next = '0;
                        if (step_idx == IW'(STEPS - 1)) begin
                            step_next = '0;
                            if (!loop_en) begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                            end
                        end else begin
                            step_next = step_idx + IW'(1);
                        end
                    end else begin
                        rcnt_next = rcnt + RW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                rcnt_next  = '0;
                step_next  = '0;
            end
        endcase
    end

    // Period counter runs only while RUN continues into the next cycle.
    assign en_c   = (state == RUN) && (state_next == RUN);
    assign duty_c = table_q[step_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= CW'(default_entry(i));
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < 5'(STEPS))) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    pwm_period_gen #(
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_period_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_c),
        .duty_in    (duty_c),
        .led        (led),
        .period_end (period_end)
    );

endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Directed bench for pwm_breath_sequencer with PERIOD=10, REPEAT=2, STEPS=4.
module tb_pwm_breath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [18:0] cfg_data;
    logic        led;
    logic        busy;
    logic [3:0]  step_idx;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int duty_exp [4];

    always #5 clk = ~clk;

    pwm_breath_sequencer #(
        .PERIOD (10),
        .REPEAT (2),
        .STEPS  (4),
        .CW     (19)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .led      (led),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    // Expected LED for RUN cycle n (n=0 is the first RUN cycle): 20 cycles per step.
    function automatic logic exp_led(input int n);
        int m;
        m = n % 80;
        return ((m % 10) < duty_exp[m / 20]);
    endfunction

    // Expected {led, busy, done, step_idx} at k cycles after RUN entry; end_k is the
    // cycle at which the sequence is back in IDLE.
    function automatic logic [6:0] exp_run(input int k, input int end_k);
        if (k < end_k) begin
            return {(k == 0) ? 1'b1 : exp_led(k - 1), 1'b1, 1'b0, 4'((k % 80) / 20)};
        end
        return {1'b1, 1'b0, (k == end_k), 4'd0};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_cfg(input logic [3:0] a, input logic [18:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(negedge clk);
        obs = {led, busy, done, step_idx};
        n_cmp++;
        if (obs !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_hold got %b exp %b", obs, 7'b1000000);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        obs = {led, busy, done, step_idx};
        n_cmp++;
        if (obs !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_idle got %b exp %b", obs, 7'b1000000);
        end
    endtask

    task automatic test_default_playback();
        logic [6:0] obs;
        duty_exp = '{475000, 425000, 350000, 250000};
        loop_en = 1'b0;
        pulse_start();
        for (int k = 0; k <= 81; k++) begin
            if (k > 0) @(negedge clk);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 80)) begin
                n_err++;
                $display("FAIL default_play k=%0d got %b exp %b", k, obs, exp_run(k, 80));
            end
        end
    endtask

    task automatic test_oneshot();
        logic [6:0] obs;
        write_cfg(4'd0, 19'd2);
        write_cfg(4'd1, 19'd5);
        write_cfg(4'd2, 19'd8);
        write_cfg(4'd3, 19'd10);
        duty_exp = '{2, 5, 8, 10};
        loop_en = 1'b0;
        pulse_start();
        for (int k = 0; k <= 81; k++) begin
            if (k > 0) @(negedge clk);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 80)) begin
                n_err++;
                $display("FAIL oneshot k=%0d got %b exp %b", k, obs, exp_run(k, 80));
            end
        end
    endtask

    task automatic test_loop();
        logic [6:0] obs;
        loop_en = 1'b1;
        pulse_start();
        for (int k = 0; k <= 321; k++) begin
            if (k > 0) @(negedge clk);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 320)) begin
                n_err++;
                $display("FAIL loop k=%0d got %b exp %b", k, obs, exp_run(k, 320));
            end
            if (k == 245) loop_en = 1'b0;
        end
    endtask

    task automatic test_stop();
        logic [6:0] obs;
        pulse_start();
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) @(negedge clk);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 80)) begin
                n_err++;
                $display("FAIL stop_pre k=%0d got %b exp %b", k, obs, exp_run(k, 80));
            end
        end
        stop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            stop = 1'b0;
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== 7'b1000000) begin
                n_err++;
                $display("FAIL stop_idle k=%0d got %b exp %b", k, obs, 7'b1000000);
            end
        end
    endtask

    task automatic test_cfg_midrun();
        logic [6:0] obs;
        logic [6:0] expv;
        pulse_start();
        for (int k = 0; k <= 81; k++) begin
            if (k > 0) @(negedge clk);
            cfg_we = 1'b0;
            expv = exp_run(k, 80);
            if (k >= 31 && k <= 40) expv[6] = 1'b0;
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL cfg_midrun k=%0d got %b exp %b", k, obs, expv);
            end
            if (k == 24) begin
                cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 19'd0;
            end
        end
        write_cfg(4'd1, 19'd5);
        write_cfg(4'd7, 19'd0);
        pulse_start();
        for (int k = 0; k <= 81; k++) begin
            if (k > 0) @(negedge clk);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 80)) begin
                n_err++;
                $display("FAIL cfg_oob k=%0d got %b exp %b", k, obs, exp_run(k, 80));
            end
        end
    endtask

    task automatic test_start_stop_conflict();
        logic [6:0] obs;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== 7'b1000000) begin
                n_err++;
                $display("FAIL start_stop k=%0d got %b exp %b", k, obs, 7'b1000000);
            end
            @(negedge clk);
        end
        pulse_start();
        for (int k = 0; k <= 81; k++) begin
            if (k > 0) @(negedge clk);
            start = (k == 5);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 80)) begin
                n_err++;
                $display("FAIL restart_ignored k=%0d got %b exp %b", k, obs, exp_run(k, 80));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] obs;
        pulse_start();
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        obs = {led, busy, done, step_idx};
        n_cmp++;
        if (obs !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_mid_run got %b exp %b", obs, 7'b1000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        duty_exp = '{475000, 425000, 350000, 250000};
        pulse_start();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            obs = {led, busy, done, step_idx};
            n_cmp++;
            if (obs !== exp_run(k, 80)) begin
                n_err++;
                $display("FAIL table_reset k=%0d got %b exp %b", k, obs, exp_run(k, 80));
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_playback();
        test_oneshot();
        test_loop();
        test_stop();
        test_cfg_midrun();
        test_start_stop_conflict();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
